// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the multiplier scheduler.
package mult_sched_pkg;

  localparam int OP_W   = 5;
  localparam int PROD_W = 10;
  localparam int ID_W   = 1;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mult_scheduler_if.sv
// Request/response bundle between the operand sources, the result consumer and
// the multiplier scheduler. The master side is the requesters plus consumer.
interface mult_scheduler_if;
  import mult_sched_pkg::*;

  logic                     req0_valid;
  logic                     req0_ready;
  logic signed [OP_W-1:0]   req0_x;
  logic signed [OP_W-1:0]   req0_y;
  logic                     req1_valid;
  logic                     req1_ready;
  logic signed [OP_W-1:0]   req1_x;
  logic signed [OP_W-1:0]   req1_y;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic signed [PROD_W-1:0] rsp_product;
  logic                     busy;

  modport master (
    output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_product, busy
  );

  modport slave (
    input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_product, busy
  );

endinterface

// File: rtl/array_multiplier.sv
// Combinational full-width signed 5x5 multiplier; -16 * -16 = +256 fits in 10 bits.
module array_multiplier
  import mult_sched_pkg::*;
(
  input  logic signed [OP_W-1:0]   x,
  input  logic signed [OP_W-1:0]   y,
  output logic signed [PROD_W-1:0] p
);

  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] y_ext;

  // Sign-extend both operands to product width before multiplying
  always_comb begin
    x_ext = $signed({{(PROD_W-OP_W){x[OP_W-1]}}, x});
    y_ext = $signed({{(PROD_W-OP_W){y[OP_W-1]}}, y});
    p     = x_ext * y_ext;
  end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-request arbiter. With MULT_SCHED_RR_EN defined a pointer register makes
// the requester that was not just granted win the next tie; otherwise
// requester 0 always wins a tie and no pointer is built.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant
);

`ifdef MULT_SCHED_RR_EN
  logic prio_q;

  // Tie goes to the pointer, otherwise to whichever requester is asserted
  always_comb begin
    grant = req[1];
    if (req[0] && req[1]) grant = prio_q;
  end

  // Pointer moves to the other requester after each completed grant
  always_ff @(posedge clk) begin
    if (rst)          prio_q <= 1'b0;
    else if (advance) prio_q <= ~grant;
  end
`else
  logic unused_ok;

  // Fixed priority: requester 1 wins only when requester 0 is idle
  always_comb begin
    grant = req[1] & ~req[0];
  end

  assign unused_ok = &{1'b0, clk, rst, advance};
`endif

endmodule

// File: rtl/mult_scheduler.sv
// Arbitrates two requesters onto the shared combinational multiplier, holds
// operands for CALC_CYCLES settle cycles, then returns the registered product.
// Arbitration is round-robin when MULT_SCHED_RR_EN is defined, fixed otherwise.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int CALC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  mult_scheduler_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CALC_CYCLES - 1);

  if (CALC_CYCLES < 1 || CALC_CYCLES > 15) begin : g_bad_calc_cycles
    $error("mult_scheduler: CALC_CYCLES must be in 1..15");
  end

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [ID_W-1:0]          id_q;
  logic signed [OP_W-1:0]   x_p0, y_p0;
  logic signed [PROD_W-1:0] mult_p0;
  logic signed [PROD_W-1:0] product_p1;
  logic                     grant, rdy0, rdy1, accept, done;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.req1_valid, bus.req0_valid}),
    .advance (accept),
    .grant   (grant)
  );

  array_multiplier u_mult (
    .x (x_p0),
    .y (y_p0),
    .p (mult_p0)
  );

  // Handshake decode: only the granted requester sees ready, never during reset
  always_comb begin
    rdy0   = !rst && (state_q == IDLE) && bus.req0_valid && (grant == 1'b0);
    rdy1   = !rst && (state_q == IDLE) && bus.req1_valid && (grant == 1'b1);
    accept = rdy0 | rdy1;
    done   = (state_q == CALC) && (cnt_q == '0);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (done) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Settle counter and owner id, loaded on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      id_q  <= '0;
    end else if (accept) begin
      cnt_q <= CNT_LOAD;
      id_q  <= grant;
    end else if ((state_q == CALC) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Stage p0: operands captured from the granted requester, held through CALC
  always_ff @(posedge clk) begin
    if (accept) begin
      x_p0 <= rdy1 ? bus.req1_x : bus.req0_x;
      y_p0 <= rdy1 ? bus.req1_y : bus.req0_y;
    end
  end

  // Stage p1: product captured once the operands have settled
  always_ff @(posedge clk) begin
    if (rst)       product_p1 <= '0;
    else if (done) product_p1 <= mult_p0;
  end

  assign bus.req0_ready  = rdy0;
  assign bus.req1_ready  = rdy1;
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_id      = id_q;
  assign bus.rsp_product = product_p1;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mult_scheduler.sv
// Bench for mult_scheduler: table of single operations, contention from reset,
// backpressure, reset during CALC and a CALC_CYCLES=3 instance.
module tb_mult_scheduler;
  import mult_sched_pkg::*;

  typedef struct {
    int         id;
    logic [4:0] x;
    logic [4:0] y;
    logic [9:0] exp;
  } vec_t;

  typedef struct {
    logic       id;
    logic [9:0] prod;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  rsp_t sb[$];
  rsp_t mon_e;
  vec_t vecs[9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_scheduler_if bus ();
  mult_scheduler_if bus3 ();

  mult_scheduler #(.CALC_CYCLES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mult_scheduler #(.CALC_CYCLES(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Scoreboard: every completed response transfer is matched against the queue
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id_prod", {bus.rsp_id, $unsigned(bus.rsp_product)}, {mon_e.id, mon_e.prod});
      end
    end
  end

  task automatic set_req(input int id, input logic v, input logic [4:0] x, input logic [4:0] y);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_x = x; bus.req0_y = y;
    end else begin
      bus.req1_valid = v; bus.req1_x = x; bus.req1_y = y;
    end
  endtask

  task automatic accept_wait(input int id, input logic [9:0] exp, input logic push);
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) seen = 1'b1;
    end
    check("accept_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      check("accept_not_busy", {31'd0, bus.busy}, 32'd0);
      check("accept_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      acc_cyc = cyc;
      if (push) sb.push_back('{id: id[0], prod: exp});
    end
    @(posedge clk); #1;
    if (id == 0) bus.req0_valid = 1'b0;
    else         bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int lat);
    logic seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("rsp_seen", {31'd0, seen}, 32'd1);
    if (seen) check("rsp_latency", cyc - acc_cyc, lat);
  endtask

  task automatic run_op(input vec_t v);
    @(posedge clk); #1;
    set_req(v.id, 1'b1, v.x, v.y);
    accept_wait(v.id, v.exp, 1'b1);
    wait_rsp(2);
  endtask

  initial begin
    int   n;
    logic seen;
    int   a;

    vecs[0] = '{0, 5'd3,  5'h1E, 10'h3FA};
    vecs[1] = '{1, 5'h10, 5'h10, 10'h100};
    vecs[2] = '{1, 5'h10, 5'd15, 10'h310};
    vecs[3] = '{0, 5'd7,  5'd7,  10'h031};
    vecs[4] = '{0, 5'd15, 5'd15, 10'h0E1};
    vecs[5] = '{1, 5'h1F, 5'h1F, 10'h001};
    vecs[6] = '{0, 5'd0,  5'h10, 10'h000};
    vecs[7] = '{1, 5'd15, 5'h10, 10'h310};
    vecs[8] = '{0, 5'h19, 5'd5,  10'h3DD};

    bus.rsp_ready = 1'b1;
    bus3.rsp_ready = 1'b1;
    bus3.req0_valid = 1'b0; bus3.req0_x = '0; bus3.req0_y = '0;
    bus3.req1_valid = 1'b0; bus3.req1_x = '0; bus3.req1_y = '0;
    rst = 1'b1;
    // Both requesters valid from reset: contention stimulus
    set_req(0, 1'b1, 5'd1, 5'd2);
    set_req(1, 1'b1, 5'd3, 5'h1D);

    @(negedge clk);
    check("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_product", {22'd0, $unsigned(bus.rsp_product)}, 32'd0);
    check("rst_id", {31'd0, bus.rsp_id}, 32'd0);
    check("rst_busy3", {31'd0, bus3.busy}, 32'd0);

`ifdef MULT_SCHED_RR_EN
    sb.push_back('{id: 1'b0, prod: 10'h002});
    sb.push_back('{id: 1'b1, prod: 10'h3F7});
    sb.push_back('{id: 1'b0, prod: 10'h002});
    sb.push_back('{id: 1'b1, prod: 10'h3F7});
`else
    for (int i = 0; i < 4; i++) sb.push_back('{id: 1'b0, prod: 10'h002});
`endif

    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) n++;
    end
    check("contention_accepts", n, 4);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("contention_drain", sb.size(), 0);

    // Single operations, one requester at a time
    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // Backpressure: result held while the consumer stalls
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 5'd5, 5'h1D);
    accept_wait(0, 10'h3F1, 1'b1);
    set_req(1, 1'b1, 5'd2, 5'd2);
    wait_rsp(2);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("bp_product", {22'd0, $unsigned(bus.rsp_product)}, 32'h3F1);
      check("bp_id", {31'd0, bus.rsp_id}, 32'd0);
      check("bp_ready1", {31'd0, bus.req1_ready}, 32'd0);
      check("bp_sb_held", sb.size(), 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    accept_wait(1, 10'h004, 1'b1);
    wait_rsp(2);

    // Reset during CALC drops the in-flight op and the arbiter pointer
    @(posedge clk); #1;
    set_req(0, 1'b1, 5'd4, 5'd4);
    accept_wait(0, 10'h000, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstcalc_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
      check("rstcalc_idle", {31'd0, bus.busy}, 32'd0);
    end
    @(posedge clk); #1;
    set_req(0, 1'b1, 5'h1F, 5'd1);
    set_req(1, 1'b1, 5'd2, 5'd3);
    accept_wait(0, 10'h3FF, 1'b1);
    bus.req1_valid = 1'b0;
    wait_rsp(2);

    // Multi-cycle settle on the CALC_CYCLES=3 instance
    @(posedge clk); #1;
    bus3.req0_valid = 1'b1; bus3.req0_x = 5'sd7; bus3.req0_y = 5'sd7;
    seen = 1'b0;
    a = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus3.req0_ready) begin seen = 1'b1; a = cyc; end
    end
    check("mc_accept", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    bus3.req0_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus3.rsp_valid) seen = 1'b1;
    end
    check("mc_rsp_seen", {31'd0, seen}, 32'd1);
    check("mc_latency", cyc - a, 4);
    check("mc_product", {22'd0, $unsigned(bus3.rsp_product)}, 32'h031);
    check("mc_id", {31'd0, bus3.rsp_id}, 32'd0);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_scheduler.md
# mult_scheduler

Sequencing and arbitration controller for the shared 5-bit signed `array_multiplier` datapath. Two requesters compete for the single multiplier through valid/ready handshakes. The block registers the granted operands, holds them stable for a programmable number of settle cycles, captures the 10-bit product, and returns it with the requester ID on a valid/ready response channel. It sits between the operand sources and the combinational multiplier and turns it into a registered, multi-cycle-path-safe resource.

## Interface
- `CALC_CYCLES`, default 1: cycles operands are held before the product is captured; legal range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an operand pair.
- `req0_ready` out 1: requester 0 operands are accepted this cycle.
- `req0_x`, `req0_y` in 5 each: requester 0 operands, two's complement.
- `req1_valid`, `req1_ready`, `req1_x`, `req1_y`: same as requester 0, for requester 1.
- `rsp_valid` out 1: a result is available.
- `rsp_ready` in 1: the consumer accepts the result.
- `rsp_id` out 1: index of the requester that owns the result.
- `rsp_product` out 10: signed product, two's complement.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **FSM states:** IDLE, CALC, RESP.
- **IDLE:**
  - The arbiter picks `grant` among the asserted valids.
  - `reqN_ready` = (state==IDLE) && valid_N && grant==N. This is combinational, and at most one ready is high.
  - When a handshake completes, `x`/`y` are latched into operand registers, `grant` is latched into `id_q`, the counter is loaded with CALC_CYCLES-1, and the FSM moves to CALC.
- **CALC:**
  - The operand registers drive the multiplier unchanged.
  - The counter decrements each cycle. On the cycle it reads 0, the multiplier output is latched into the `rsp_product` register and the FSM moves to RESP.
- **RESP:**
  - `rsp_valid`=1, and `rsp_product`/`rsp_id` hold stable until `rsp_valid && rsp_ready`. The FSM then returns to IDLE.
  - No new request is accepted in the RESP cycle.
- **Arithmetic:**
  - The product is the full signed 5x5 result, with range -240..256. There is no overflow, and no sign or width truncation is permitted.
  - -16 × -16 = +256 must be returned correctly.
- **Requester rules:**
  - A requester holds valid and data stable until ready.
  - Valid must not depend on ready.
  - Deasserting valid before ready is allowed; that request is simply not served.

## Timing
- **Reset values** (next edge after `rst`=1): state IDLE; `rsp_valid`=0, `rsp_product`=0, `rsp_id`=0, `busy`=0; both readies 0 combinationally in the reset cycle; round-robin pointer set so that requester 0 wins the first tie.
- **Latency:** accept at edge t, then `rsp_valid` high in cycle t+CALC_CYCLES+1. With the default this is the 2nd cycle after acceptance.
- **Throughput:** with `rsp_ready` tied high, at most one op per CALC_CYCLES+2 cycles.
- **Backpressure:** `rsp_ready` low holds RESP indefinitely. Requesters see ready=0 throughout.
- **Simultaneous valids:** decided by the arbiter (see Configuration). Exactly one requester is granted.
- **Reset mid-operation** (CALC or RESP): the in-flight op is dropped, no response is produced, the FSM returns to IDLE, and the pointer is reset.
- **Illegal parameter:** CALC_CYCLES=0 is illegal and is rejected by an elaboration-time check.

## Configuration
- **`MULT_SCHED_RR_EN` defined:**
  - Round-robin arbitration. After a grant to N, the other requester wins the next tie.
  - Both requesters continuously valid are served alternately.
- **Not defined:**
  - Fixed priority, with requester 0 always winning a tie. Requester 1 can be starved.
  - The pointer register is not built.

## Structure
- **Package `mult_sched_pkg`:**
  - State enum (IDLE, CALC, RESP).
  - Operand width 5, product width 10, ID width 1.
  - Counter width 4.
- **Sub-module `rr_arbiter2`:**
  - Two-request arbiter with pointer register, using `clk`/`rst`.
  - Inputs: `req[1:0]`, `advance`.
  - Output: `grant`.
  - Under the macro-off build it degenerates to fixed priority.
- **Top:** instantiates `rr_arbiter2` and `array_multiplier`, plus the FSM, counter and registers.

## Test plan
- **Single op:** req0 x=3, y=-2 (5'h1E) alone → `rsp_valid` at accept+2, `rsp_product`=10'h3FA, `rsp_id`=0.
- **Extreme operands:** req1 x=-16, y=-16 → 10'h100, `rsp_id`=1. Also x=-16, y=15 → 10'h310.
- **Contention:** both valid every cycle from reset with RR_EN, 4 ops → ids 0,1,0,1. Without RR_EN → ids 0,0,0,0.
- **Backpressure:** `rsp_ready` low for 5 cycles in RESP → product and id stable, both readies 0, then one transfer on release.
- **Multi-cycle settle:** CALC_CYCLES=3, x=7, y=7 → `rsp_valid` at accept+4, product 10'h031.
- **Reset in CALC:** `rst` for one cycle during CALC → no `rsp_valid`. Next req x=-1, y=1 yields 10'h3FF, with the tie going to requester 0.
